// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the
// datapath / instruction and data memories (slave).
interface multicycle_ctrl_if #(
  parameter int I_WIDTH = 32
);
  logic [I_WIDTH-1:0] instr;
  logic               instr_valid;
  logic               mem_ready;
  logic               eq;

  logic               ir_en;
  logic               pc_en;
  logic [1:0]         pcsrc;
  logic [1:0]         op1src;
  logic               alusrc;
  logic [3:0]         aluctrl;
  logic [2:0]         immsrc;
  logic               memread;
  logic               memwrite;
  logic               regwrite;
  logic [1:0]         resultsrc;
  logic               illegal;

  modport master (
    input  instr, instr_valid, mem_ready, eq,
    output ir_en, pc_en, pcsrc, op1src, alusrc, aluctrl, immsrc,
           memread, memwrite, regwrite, resultsrc, illegal
  );

  modport slave (
    output instr, instr_valid, mem_ready, eq,
    input  ir_en, pc_en, pcsrc, op1src, alusrc, aluctrl, immsrc,
           memread, memwrite, regwrite, resultsrc, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer that
// drives the ALU, memory, writeback and PC controls from latched opcode fields.
module multicycle_ctrl #(
  parameter int I_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ILLEGAL
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_IALU, C_LOAD, C_STORE, C_BRANCH,
    C_JAL, C_JALR, C_LUI, C_AUIPC, C_NONE
  } iclass_t;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                         IMM_U = 3'b011, IMM_J = 3'b100;
  localparam logic [1:0] PC_PLUS4 = 2'b00, PC_IMM = 2'b01, PC_ALU = 2'b10;

  state_t     state, state_nx;
  iclass_t    iclass;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       accept;
  logic       taken;

  assign accept = (state == S_FETCH) && bus.instr_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      opcode   <= '0;
      funct3   <= '0;
      funct7b5 <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        opcode   <= bus.instr[6:0];
        funct3   <= bus.instr[14:12];
        funct7b5 <= bus.instr[I_WIDTH-2];
      end
    end
  end

  always_comb begin
    case (opcode)
      7'b0110011: iclass = C_RTYPE;
      7'b0010011: iclass = C_IALU;
      7'b0000011: iclass = C_LOAD;
      7'b0100011: iclass = C_STORE;
      7'b1100011: iclass = C_BRANCH;
      7'b1101111: iclass = C_JAL;
      7'b1100111: iclass = C_JALR;
      7'b0110111: iclass = C_LUI;
      7'b0010111: iclass = C_AUIPC;
      default:    iclass = C_NONE;
    endcase
  end

  // eq is the XOR-nonzero flag for BEQ/BNE and the SLT/SLTU bit otherwise;
  // funct3[0] inverts the sense, funct3[2] separates equality from compare.
  assign taken = bus.eq ^ funct3[0] ^ ~funct3[2];

  // NOTE: every output and state_nx gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_nx      = state;
    bus.ir_en     = 1'b0;
    bus.pc_en     = 1'b0;
    bus.pcsrc     = PC_PLUS4;
    bus.op1src    = 2'b00;
    bus.alusrc    = 1'b0;
    bus.aluctrl   = 4'b0000;
    bus.immsrc    = IMM_I;
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.regwrite  = 1'b0;
    bus.resultsrc = 2'b00;
    bus.illegal   = 1'b0;

    case (state)
      S_FETCH: begin
        // Gated by rst_n so every output reads zero while reset is held.
        bus.ir_en = accept & rst_n;
        if (accept) state_nx = S_DECODE;
      end

      S_DECODE: begin
        if (iclass == C_NONE || (iclass == C_BRANCH && funct3[2:1] == 2'b01))
          state_nx = S_ILLEGAL;
        else
          state_nx = S_EXEC;
      end

      S_EXEC: begin
        state_nx = S_WB;
        case (iclass)
          C_RTYPE: bus.aluctrl = {funct7b5, funct3};
          C_IALU: begin
            bus.alusrc  = 1'b1;
            bus.aluctrl = {funct7b5 & (funct3 == 3'b101), funct3};
          end
          C_LOAD, C_STORE: begin
            bus.alusrc = 1'b1;
            bus.immsrc = (iclass == C_STORE) ? IMM_S : IMM_I;
            state_nx   = S_MEM;
          end
          C_BRANCH: begin
            bus.immsrc  = IMM_B;
            bus.aluctrl = funct3[2] ? (funct3[1] ? 4'b0011 : 4'b0010) : 4'b0100;
            bus.pc_en   = 1'b1;
            bus.pcsrc   = taken ? PC_IMM : PC_PLUS4;
            state_nx    = S_FETCH;
          end
          C_JAL: begin
            bus.immsrc = IMM_J;
            bus.pc_en  = 1'b1;
            bus.pcsrc  = PC_IMM;
          end
          C_JALR: begin
            bus.alusrc = 1'b1;
            bus.pc_en  = 1'b1;
            bus.pcsrc  = PC_ALU;
          end
          C_LUI, C_AUIPC: begin
            bus.op1src = (iclass == C_LUI) ? 2'b10 : 2'b01;
            bus.alusrc = 1'b1;
            bus.immsrc = IMM_U;
          end
          default: state_nx = S_ILLEGAL;
        endcase
      end

      S_MEM: begin
        bus.alusrc   = 1'b1;
        bus.immsrc   = (iclass == C_STORE) ? IMM_S : IMM_I;
        bus.memread  = (iclass == C_LOAD);
        bus.memwrite = (iclass == C_STORE);
        if (bus.mem_ready) begin
          if (iclass == C_STORE) begin
            bus.pc_en = 1'b1;
            state_nx  = S_FETCH;
          end else begin
            state_nx  = S_WB;
          end
        end
      end

      S_WB: begin
        bus.regwrite = 1'b1;
        if (iclass == C_LOAD)
          bus.resultsrc = 2'b01;
        else if (iclass == C_JAL || iclass == C_JALR)
          bus.resultsrc = 2'b10;
        // Jumps already redirected the PC in EXEC.
        bus.pc_en = !(iclass == C_JAL || iclass == C_JALR);
        state_nx  = S_FETCH;
      end

      S_ILLEGAL: bus.illegal = 1'b1;

      default: state_nx = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: inputs change on the falling
// edge, outputs are compared 1 time unit later, well before the rising edge.
module tb_multicycle_ctrl;

  logic clk;
  logic rst_n;

  multicycle_ctrl_if #(.I_WIDTH(32)) bus ();

  multicycle_ctrl #(.I_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [31:0] I_ADD   = 32'h00208033;
  localparam logic [31:0] I_SUB   = 32'h40208033;
  localparam logic [31:0] I_SRAI  = 32'h4030D093;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BGE   = 32'h0020D463;
  localparam logic [31:0] I_BRX   = 32'h00202463;
  localparam logic [31:0] I_LW    = 32'h0000A083;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_FENCE = 32'h0000000F;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] outs;
  assign outs = {bus.ir_en, bus.pc_en, bus.pcsrc, bus.op1src, bus.alusrc,
                 bus.aluctrl, bus.immsrc, bus.memread, bus.memwrite,
                 bus.regwrite, bus.resultsrc, bus.illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] i, input logic mr, input logic e);
    @(negedge clk);
    bus.instr_valid = v;
    bus.instr       = i;
    bus.mem_ready   = mr;
    bus.eq          = e;
    #1;
  endtask

  task automatic run_alu(input string tag, input logic [31:0] i,
                         input logic [31:0] exp_ctrl, input logic [31:0] exp_src);
    step(1'b1, i, 1'b0, 1'b0);
    check({tag, "_c0_ir_en"}, 32'(bus.ir_en), 1);
    step(1'b0, '0, 1'b0, 1'b0);
    check({tag, "_c1_decode_quiet"}, 32'(outs), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check({tag, "_c2_aluctrl"}, 32'(bus.aluctrl), exp_ctrl);
    check({tag, "_c2_alusrc"}, 32'(bus.alusrc), exp_src);
    check({tag, "_c2_regwrite"}, 32'(bus.regwrite), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check({tag, "_c3_regwrite"}, 32'(bus.regwrite), 1);
    check({tag, "_c3_resultsrc"}, 32'(bus.resultsrc), 0);
    check({tag, "_c3_pc_en"}, 32'(bus.pc_en), 1);
    check({tag, "_c3_pcsrc"}, 32'(bus.pcsrc), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check({tag, "_c4_fetch_quiet"}, 32'(outs), 0);
  endtask

  task automatic run_branch(input string tag, input logic [31:0] i, input logic e,
                            input logic [31:0] exp_ctrl, input logic [31:0] exp_pcsrc);
    step(1'b1, i, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, e);
    check({tag, "_decode_quiet"}, 32'(outs), 0);
    step(1'b0, '0, 1'b0, e);
    check({tag, "_aluctrl"}, 32'(bus.aluctrl), exp_ctrl);
    check({tag, "_alusrc"}, 32'(bus.alusrc), 0);
    check({tag, "_immsrc"}, 32'(bus.immsrc), 2);
    check({tag, "_pc_en"}, 32'(bus.pc_en), 1);
    check({tag, "_pcsrc"}, 32'(bus.pcsrc), exp_pcsrc);
    check({tag, "_regwrite"}, 32'(bus.regwrite), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check({tag, "_fetch_quiet"}, 32'(outs), 0);
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] i);
    step(1'b1, i, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check({tag, "_decode_illegal"}, 32'(bus.illegal), 0);
    step(1'b1, I_ADD, 1'b0, 1'b0);
    check({tag, "_trap_illegal"}, 32'(bus.illegal), 1);
    check({tag, "_trap_ir_en"}, 32'(bus.ir_en), 0);
    step(1'b1, I_ADD, 1'b1, 1'b1);
    check({tag, "_sticky_outs"}, 32'(outs), 32'h1);
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    #1;
    check({tag, "_reset_clears"}, 32'(bus.illegal), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr       = I_ADD;
    bus.mem_ready   = 1'b0;
    bus.eq          = 1'b0;
    #3;
    check("reset_outs", 32'(outs), 0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst_n           = 1'b1;

    run_alu("add",  I_ADD,  0,     0);
    run_alu("sub",  I_SUB,  32'h8, 0);
    run_alu("srai", I_SRAI, 32'hD, 1);

    run_branch("beq_eq0", I_BEQ, 1'b0, 32'h4, 1);
    run_branch("beq_eq1", I_BEQ, 1'b1, 32'h4, 0);
    run_branch("bge_eq1", I_BGE, 1'b1, 32'h2, 0);

    // LW: mem_ready pulsed in EXEC must be ignored, then 3 waits + 1 ready.
    step(1'b1, I_LW, 1'b0, 1'b0);
    check("lw_ir_en", 32'(bus.ir_en), 1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("lw_exec_memread", 32'(bus.memread), 0);
    check("lw_exec_alusrc", 32'(bus.alusrc), 1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, (k == 3), 1'b0);
      check($sformatf("lw_mem%0d_memread", k), 32'(bus.memread), 1);
      check($sformatf("lw_mem%0d_regwrite", k), 32'(bus.regwrite), 0);
      check($sformatf("lw_mem%0d_pc_en", k), 32'(bus.pc_en), 0);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    check("lw_wb_regwrite", 32'(bus.regwrite), 1);
    check("lw_wb_resultsrc", 32'(bus.resultsrc), 1);
    check("lw_wb_pc_en", 32'(bus.pc_en), 1);
    check("lw_wb_memread", 32'(bus.memread), 0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, I_ADD, 1'b0, 1'b0);
      check($sformatf("idle%0d_outs", k), 32'(outs), 0);
    end

    // SW completing on its first MEM cycle.
    step(1'b1, I_SW, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("sw_exec_immsrc", 32'(bus.immsrc), 1);
    check("sw_exec_memwrite", 32'(bus.memwrite), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("sw_mem_memwrite", 32'(bus.memwrite), 1);
    check("sw_mem_pc_en", 32'(bus.pc_en), 1);
    check("sw_mem_pcsrc", 32'(bus.pcsrc), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("sw_after_outs", 32'(outs), 0);

    // JAL: PC moves in EXEC, WB writes PC+4 without a second pc_en.
    step(1'b1, I_JAL, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("jal_exec_pc_en", 32'(bus.pc_en), 1);
    check("jal_exec_pcsrc", 32'(bus.pcsrc), 1);
    check("jal_exec_immsrc", 32'(bus.immsrc), 4);
    step(1'b0, '0, 1'b0, 1'b0);
    check("jal_wb_regwrite", 32'(bus.regwrite), 1);
    check("jal_wb_resultsrc", 32'(bus.resultsrc), 2);
    check("jal_wb_pc_en", 32'(bus.pc_en), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("jal_after_outs", 32'(outs), 0);

    run_illegal("fence", I_FENCE);
    run_alu("post_fence_add", I_ADD, 0, 0);
    run_illegal("br010", I_BRX);

    // SW interrupted by reset in MEM: memwrite must drop without a clock edge.
    step(1'b1, I_SW, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("swrst_mem_memwrite", 32'(bus.memwrite), 1);
    rst_n = 1'b0;
    #1;
    check("swrst_async_memwrite", 32'(bus.memwrite), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    check("swrst_release_outs", 32'(outs), 0);
    step(1'b1, I_ADD, 1'b0, 1'b0);
    check("swrst_fetch_ir_en", 32'(bus.ir_en), 1);
    step(1'b0, '0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
